// File: rtl/memory_pkg.sv
// Shared definitions for the memory-access pipeline stage: access size codes
// and the request FSM state type.
package memory_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/memory_load_extend.sv
// Load-data alignment: picks the addressed byte/half lane out of a little-endian
// 32-bit read word and sign- or zero-extends it to 32 bits.
module load_extend
    import memory_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[8*addr +: 8];
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            MEM_BYTE: data = is_signed ? {{24{byte_lane[7]}}, byte_lane} : {24'b0, byte_lane};
            MEM_HALF: data = is_signed ? {{16{half_lane[15]}}, half_lane} : {16'b0, half_lane};
            default:  data = rdata;
        endcase
    end

endmodule

// File: rtl/memory.sv
// MIPS memory-access stage: issues data-memory requests over req/ack, stalls
// upstream while an access is in flight, and drives the MEM/WB pipeline register.
module memory
    import memory_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_mem,
    input  logic [DATA_WIDTH-1:0] alu_data_mem,
    input  logic [DATA_WIDTH-1:0] rt_data_mem,
    input  logic                  mem_read_mem,
    input  logic                  mem_write_mem,
    input  logic [1:0]            mem_size_mem,
    input  logic                  mem_signed_mem,
    input  logic [ADDR_WIDTH-1:0] reg_d_addr_mem,
    input  logic                  reg_d_we_mem,
    input  logic                  reg_d_data_sel_mem,
    output logic                  stall_mem,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic [DATA_WIDTH-1:0] alu_data_wb,
    output logic [DATA_WIDTH-1:0] mem_data_wb,
    output logic                  reg_d_data_sel_wb,
    output logic [ADDR_WIDTH-1:0] reg_d_addr_wb,
    output logic                  reg_d_we_wb,
    output logic                  misalign_wb
);

    // Handshake: dmem_req rises the cycle after an access is accepted and the
    // dmem_* outputs stay frozen until the cycle dmem_ack is seen high; that
    // cycle completes the transfer and dmem_req drops at the following edge.

    state_t state, state_next;
    logic access, aligned, start, done;
    logic [3:0] be_next;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic [31:0] load_data;

    // Captured instruction, replayed into the WB register when the ack arrives.
    logic [DATA_WIDTH-1:0] cap_alu;
    logic [1:0] cap_size;
    logic cap_signed, cap_we, cap_sel;
    logic [ADDR_WIDTH-1:0] cap_rd;

    always_comb begin
        access = valid_mem & (mem_read_mem | mem_write_mem);
        case (mem_size_mem)
            MEM_BYTE: aligned = 1'b1;
            MEM_HALF: aligned = ~alu_data_mem[0];
            default:  aligned = (alu_data_mem[1:0] == 2'b00);
        endcase
        case (mem_size_mem)
            MEM_BYTE: begin
                be_next    = 4'b0001 << alu_data_mem[1:0];
                wdata_next = {4{rt_data_mem[7:0]}};
            end
            MEM_HALF: begin
                be_next    = alu_data_mem[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{rt_data_mem[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = rt_data_mem;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (access && aligned) state_next = BUSY;
            BUSY: if (dmem_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        start     = (state == IDLE) && access && aligned;
        done      = (state == BUSY) && dmem_ack;
        stall_mem = (state == IDLE) ? start : ~dmem_ack;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'b0;
            dmem_wdata <= '0;
            cap_alu    <= '0;
            cap_size   <= MEM_BYTE;
            cap_signed <= 1'b0;
            cap_we     <= 1'b0;
            cap_sel    <= 1'b0;
            cap_rd     <= '0;
        end else if (start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write_mem;
            dmem_addr  <= {alu_data_mem[DATA_WIDTH-1:2], 2'b00};
            dmem_be    <= be_next;
            dmem_wdata <= wdata_next;
            cap_alu    <= alu_data_mem;
            cap_size   <= mem_size_mem;
            cap_signed <= mem_signed_mem;
            cap_we     <= reg_d_we_mem;
            cap_sel    <= reg_d_data_sel_mem;
            cap_rd     <= reg_d_addr_mem;
        end else if (done) begin
            dmem_req <= 1'b0;
        end
    end

    load_extend u_load_extend (
        .rdata     (dmem_rdata),
        .addr      (cap_alu[1:0]),
        .size      (cap_size),
        .is_signed (cap_signed),
        .data      (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_data_wb       <= '0;
            mem_data_wb       <= '0;
            reg_d_data_sel_wb <= 1'b0;
            reg_d_addr_wb     <= '0;
            reg_d_we_wb       <= 1'b0;
            misalign_wb       <= 1'b0;
        end else if (done) begin
            alu_data_wb       <= cap_alu;
            mem_data_wb       <= load_data;
            reg_d_data_sel_wb <= cap_sel;
            reg_d_addr_wb     <= cap_rd;
            reg_d_we_wb       <= cap_we;
            misalign_wb       <= 1'b0;
        end else if (state == IDLE && valid_mem && (!access || !aligned)) begin
            // Misaligned accesses are dropped: they pass through with writes disabled.
            alu_data_wb       <= alu_data_mem;
            reg_d_data_sel_wb <= reg_d_data_sel_mem;
            reg_d_addr_wb     <= reg_d_addr_mem;
            reg_d_we_wb       <= access ? 1'b0 : reg_d_we_mem;
            misalign_wb       <= access;
        end else begin
            reg_d_we_wb <= 1'b0;
            misalign_wb <= 1'b0;
        end
    end

endmodule
